// File: rtl/control_unit.sv
`default_nettype none
// control_unit: four-state (FETCH/DECODE/EX1/EX2) instruction sequencer holding
// PC, IR and flags, with an 8-deep internal call/return stack of {PC, flags}.
module control_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] in_ir,
  input  logic [3:0]  in_alu_flags,
  output logic [15:0] out_ir,
  output logic [3:0]  out_flags,
  output logic [7:0]  out_cu_out,
  output logic [8:0]  out_pc,
  output logic        out_alu_enable_out,
  output logic        out_mbs_wr_enable,
  output logic        out_data_memory_read_enable,
  output logic        out_data_memory_wr_enable,
  output logic        out_data_memory_addr_wr_enable,
  output logic        out_reg_write_en,
  output logic        out_reg_read_en
);

  localparam logic [1:0] FETCH  = 2'd0;
  localparam logic [1:0] DECODE = 2'd1;
  localparam logic [1:0] EX1    = 2'd2;
  localparam logic [1:0] EX2    = 2'd3;

  localparam logic [4:0] OP_COPY   = 5'b01000;
  localparam logic [4:0] OP_SET    = 5'b01001;
  localparam logic [4:0] OP_JMP    = 5'b10000;
  localparam logic [4:0] OP_JMPEQ  = 5'b10001;
  localparam logic [4:0] OP_JMPNEQ = 5'b10010;
  localparam logic [4:0] OP_CALL   = 5'b10100;
  localparam logic [4:0] OP_RET    = 5'b10101;
  localparam logic [4:0] OP_GETF   = 5'b11000;
  localparam logic [4:0] OP_SELB   = 5'b11001;
  localparam logic [4:0] OP_WRITE  = 5'b11100;
  localparam logic [4:0] OP_READ   = 5'b11101;

  localparam int STACK_DEPTH = 8;
  localparam logic [3:0] SP_FULL = 4'd8;

  logic [1:0]  state;
  logic [1:0]  state_next;
  logic [15:0] ir;
  logic [8:0]  pc;
  logic [3:0]  flags;
  logic [12:0] stack_mem [STACK_DEPTH];
  logic [3:0]  sp;

  logic [4:0]  opcode;
  logic [8:0]  target;
  logic        is_alu;
  logic        is_valid;
  logic        is_two_ex;
  logic        jump_taken;
  logic        stack_full;
  logic        stack_empty;
  logic [12:0] stack_top;

  assign opcode      = ir[15:11];
  assign target      = ir[10:2];
  assign is_alu      = (opcode[4:3] == 2'b00);
  assign is_two_ex   = (opcode == OP_CALL) || (opcode == OP_WRITE) || (opcode == OP_READ);
  assign stack_full  = (sp == SP_FULL);
  assign stack_empty = (sp == 4'd0);
  // sp counts 0..8; the entry below sp is the top (sp=8 wraps to index 7)
  assign stack_top   = stack_mem[sp[2:0] - 3'd1];

  always_comb begin
    is_valid = is_alu;
    case (opcode)
      OP_COPY, OP_SET, OP_JMP, OP_JMPEQ, OP_JMPNEQ, OP_CALL, OP_RET,
      OP_GETF, OP_SELB, OP_WRITE, OP_READ: is_valid = 1'b1;
      default: ;
    endcase
  end

  always_comb begin
    jump_taken = 1'b0;
    case (opcode)
      OP_JMP:    jump_taken = 1'b1;
      OP_JMPEQ:  jump_taken = flags[0];
      OP_JMPNEQ: jump_taken = ~flags[0];
      default:   jump_taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= FETCH;
    else     state <= state_next;
  end

  always_comb begin
    state_next = FETCH;
    case (state)
      FETCH:   state_next = DECODE;
      DECODE:  state_next = is_valid ? EX1 : FETCH;
      EX1:     state_next = is_two_ex ? EX2 : FETCH;
      default: state_next = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ir    <= 16'h0000;
      pc    <= 9'h000;
      flags <= 4'h0;
      sp    <= 4'd0;
    end else begin
      case (state)
        FETCH:  ir <= in_ir;
        DECODE: pc <= pc + 9'd1;
        EX1: begin
          if (is_alu) flags <= in_alu_flags;
          if (jump_taken) pc <= target;
          if (opcode == OP_CALL && !stack_full) sp <= sp + 4'd1;
          if (opcode == OP_RET) begin
            if (stack_empty) begin
              pc    <= 9'h000;
              flags <= 4'h0;
            end else begin
              pc    <= stack_top[12:4];
              flags <= stack_top[3:0];
              sp    <= sp - 4'd1;
            end
          end
        end
        default: if (opcode == OP_CALL) pc <= target;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && state == EX1 && opcode == OP_CALL && !stack_full)
      stack_mem[sp[2:0]] <= {pc, flags};
  end

  always_comb begin
    out_cu_out                     = 8'h00;
    out_alu_enable_out             = 1'b0;
    out_mbs_wr_enable              = 1'b0;
    out_data_memory_read_enable    = 1'b0;
    out_data_memory_wr_enable      = 1'b0;
    out_data_memory_addr_wr_enable = 1'b0;
    out_reg_write_en               = 1'b0;
    out_reg_read_en                = 1'b0;
    if (state == EX1) begin
      if (is_alu) begin
        out_alu_enable_out = 1'b1;
        out_reg_write_en   = (ir[13:11] != 3'b111);
      end else begin
        case (opcode)
          OP_COPY: begin
            out_reg_read_en  = 1'b1;
            out_reg_write_en = 1'b1;
          end
          OP_SET: begin
            out_cu_out       = ir[7:0];
            out_reg_write_en = 1'b1;
          end
          OP_GETF: begin
            out_cu_out       = {4'b0000, flags};
            out_reg_write_en = 1'b1;
          end
          OP_SELB: begin
            out_cu_out        = {6'b000000, ir[10:9]};
            out_mbs_wr_enable = 1'b1;
          end
          OP_WRITE, OP_READ: begin
            out_cu_out                     = ir[7:0];
            out_data_memory_addr_wr_enable = 1'b1;
          end
          default: ;
        endcase
      end
    end else if (state == EX2) begin
      case (opcode)
        OP_WRITE: begin
          out_reg_read_en           = 1'b1;
          out_data_memory_wr_enable = 1'b1;
        end
        OP_READ: begin
          out_data_memory_read_enable = 1'b1;
          out_reg_write_en            = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign out_ir    = ir;
  assign out_flags = flags;
  assign out_pc    = pc;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// tb_control_unit: runs short programs from a bench code memory; expected events
// (cycles where the unit drives something or PC/flags move) are scoreboarded.
module tb_control_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] in_ir;
  logic [3:0]  in_alu_flags;
  logic [15:0] out_ir;
  logic [3:0]  out_flags;
  logic [7:0]  out_cu_out;
  logic [8:0]  out_pc;
  logic        alu_en, mbs_en, dm_rd, dm_wr, dm_addr, reg_wr, reg_rd;

  logic [15:0] imem [512];
  logic [3:0]  flag_xor = 4'h0;

  localparam logic [15:0] NOP = 16'hF800;
  localparam logic [15:0] RET = 16'hA800;
  localparam logic [15:0] ADD = 16'h0140;
  localparam logic [6:0] EN_ALU  = 7'b1000000;
  localparam logic [6:0] EN_MBS  = 7'b0100000;
  localparam logic [6:0] EN_DMRD = 7'b0010000;
  localparam logic [6:0] EN_DMWR = 7'b0001000;
  localparam logic [6:0] EN_ADDR = 7'b0000100;
  localparam logic [6:0] EN_RW   = 7'b0000010;
  localparam logic [6:0] EN_RR   = 7'b0000001;

  // code memory addressed by PC; a fake ALU derives flags from the PC
  assign in_ir        = imem[out_pc];
  assign in_alu_flags = out_pc[3:0] ^ flag_xor;

  always #5 clk = ~clk;

  control_unit dut (
    .clk                            (clk),
    .rst                            (rst),
    .in_ir                          (in_ir),
    .in_alu_flags                   (in_alu_flags),
    .out_ir                         (out_ir),
    .out_flags                      (out_flags),
    .out_cu_out                     (out_cu_out),
    .out_pc                         (out_pc),
    .out_alu_enable_out             (alu_en),
    .out_mbs_wr_enable              (mbs_en),
    .out_data_memory_read_enable    (dm_rd),
    .out_data_memory_wr_enable      (dm_wr),
    .out_data_memory_addr_wr_enable (dm_addr),
    .out_reg_write_en               (reg_wr),
    .out_reg_read_en                (reg_rd)
  );

  logic [6:0]  en_vec;
  logic [27:0] obs;
  assign en_vec = {alu_en, mbs_en, dm_rd, dm_wr, dm_addr, reg_wr, reg_rd};
  assign obs    = {out_pc, out_flags, out_cu_out, en_vec};

  int          vectors = 0;
  int          miscompares = 0;
  logic [27:0] exp_q[$];
  logic [27:0] exp_e;
  logic        rst_edge = 1'b1;
  logic        mon_en = 1'b0;
  logic        done = 1'b0;
  logic        reported = 1'b0;
  logic [8:0]  prev_pc = 9'h000;
  logic [3:0]  prev_flags = 4'h0;

  task automatic expect_ev(input logic [8:0] pc, input logic [3:0] fl,
                           input logic [7:0] cu, input logic [6:0] en);
    exp_q.push_back({pc, fl, cu, en});
  endtask

  function automatic logic [15:0] call_op(input logic [8:0] t);
    return {5'b10100, t, 2'b00};
  endfunction

  task automatic clear_imem();
    for (int i = 0; i < 512; i++) imem[i] = NOP;
  endtask

  // release reset, observe cycles 0..n, then reset mid-flight during cycle n
  task automatic run_seg(input int n);
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  always @(posedge clk) rst_edge <= rst;

  always @(negedge clk) begin
    if (mon_en) begin
      if (rst_edge) begin
        vectors++;
        if (obs !== 28'd0 || out_ir !== 16'h0000) begin
          miscompares++;
          $display("FAIL reset_state: got pc=%h fl=%h cu=%h en=%b ir=%h, want all zero",
                   out_pc, out_flags, out_cu_out, en_vec, out_ir);
        end
      end else if (out_pc != prev_pc || out_flags != prev_flags || obs[14:0] != 15'd0) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_event: got pc=%h fl=%h cu=%h en=%b, want no event",
                   out_pc, out_flags, out_cu_out, en_vec);
        end else begin
          exp_e = exp_q.pop_front();
          if (obs !== exp_e) begin
            miscompares++;
            $display("FAIL event: got pc=%h fl=%h cu=%h en=%b, want pc=%h fl=%h cu=%h en=%b",
                     out_pc, out_flags, out_cu_out, en_vec,
                     exp_e[27:19], exp_e[18:15], exp_e[14:7], exp_e[6:0]);
          end
        end
      end
      prev_pc    = out_pc;
      prev_flags = out_flags;
    end
    if (done && !reported) begin
      reported = 1'b1;
      while (exp_q.size() > 0) begin
        exp_e = exp_q.pop_front();
        vectors++;
        miscompares++;
        $display("FAIL missing_event: got none, want pc=%h fl=%h cu=%h en=%b",
                 exp_e[27:19], exp_e[18:15], exp_e[14:7], exp_e[6:0]);
      end
    end
  end

  initial begin
    clear_imem();
    repeat (2) @(posedge clk);
    #1 mon_en = 1'b1;

    // set imm8 -> bus
    clear_imem();
    imem[0] = 16'h4BF0;
    expect_ev(9'h001, 4'h0, 8'hF0, EN_RW);
    run_seg(4);

    // add with Z=1 then jmpeq taken
    clear_imem();
    flag_xor = 4'h0;
    imem[0] = ADD;
    imem[1] = 16'h8FC0;
    expect_ev(9'h001, 4'h0, 8'h00, EN_ALU | EN_RW);
    expect_ev(9'h001, 4'h1, 8'h00, 7'd0);
    expect_ev(9'h002, 4'h1, 8'h00, 7'd0);
    expect_ev(9'h1F0, 4'h1, 8'h00, 7'd0);
    run_seg(6);

    // same with Z=0: jmpeq falls through
    flag_xor = 4'h1;
    expect_ev(9'h001, 4'h0, 8'h00, EN_ALU | EN_RW);
    expect_ev(9'h002, 4'h0, 8'h00, 7'd0);
    run_seg(7);

    // cmp (no write-back), getflags, selbank, copy
    clear_imem();
    flag_xor = 4'h8;
    imem[0] = 16'h3820;
    imem[1] = 16'hC300;
    imem[2] = 16'hCC00;
    imem[3] = 16'h4140;
    expect_ev(9'h001, 4'h0, 8'h00, EN_ALU);
    expect_ev(9'h001, 4'h9, 8'h00, 7'd0);
    expect_ev(9'h002, 4'h9, 8'h09, EN_RW);
    expect_ev(9'h003, 4'h9, 8'h02, EN_MBS);
    expect_ev(9'h004, 4'h9, 8'h00, EN_RW | EN_RR);
    run_seg(11);

    // call at PC=5, flags changed in callee, ret restores PC and flags
    clear_imem();
    flag_xor = 4'h0;
    imem[0] = ADD;
    imem[5] = 16'hA784;
    imem[9'h1E1] = ADD;
    imem[9'h1E2] = RET;
    expect_ev(9'h001, 4'h0, 8'h00, EN_ALU | EN_RW);
    expect_ev(9'h001, 4'h1, 8'h00, 7'd0);
    for (int k = 2; k <= 6; k++) expect_ev(9'(k), 4'h1, 8'h00, 7'd0);
    expect_ev(9'h1E1, 4'h1, 8'h00, 7'd0);
    expect_ev(9'h1E2, 4'h1, 8'h00, EN_ALU | EN_RW);
    expect_ev(9'h1E2, 4'h2, 8'h00, 7'd0);
    expect_ev(9'h1E3, 4'h2, 8'h00, 7'd0);
    expect_ev(9'h006, 4'h1, 8'h00, 7'd0);
    run_seg(21);

    // write, read, then a write aborted by reset after EX1
    clear_imem();
    imem[0] = 16'hE2F0;
    imem[1] = 16'hEB0F;
    imem[2] = 16'hE2F0;
    expect_ev(9'h001, 4'h0, 8'hF0, EN_ADDR);
    expect_ev(9'h001, 4'h0, 8'h00, EN_RR | EN_DMWR);
    expect_ev(9'h002, 4'h0, 8'h0F, EN_ADDR);
    expect_ev(9'h002, 4'h0, 8'h00, EN_DMRD | EN_RW);
    expect_ev(9'h003, 4'h0, 8'hF0, EN_ADDR);
    run_seg(10);

    // nine nested calls (ninth push dropped), nine rets (last pops empty)
    clear_imem();
    flag_xor = 4'h0;
    for (int k = 0; k < 9; k++) imem[16 * k] = call_op(9'(16 * (k + 1)));
    imem[9'h090] = RET;
    for (int j = 1; j <= 7; j++) imem[16 * j + 1] = RET;
    imem[1] = ADD;
    imem[2] = RET;
    for (int k = 0; k < 9; k++) begin
      expect_ev(9'(16 * k + 1), 4'h0, 8'h00, 7'd0);
      expect_ev(9'(16 * (k + 1)), 4'h0, 8'h00, 7'd0);
    end
    expect_ev(9'h091, 4'h0, 8'h00, 7'd0);
    expect_ev(9'h071, 4'h0, 8'h00, 7'd0);
    for (int j = 0; j < 7; j++) begin
      expect_ev(9'(9'h071 - 16 * j + 1), 4'h0, 8'h00, 7'd0);
      expect_ev(9'(9'h071 - 16 * j - 16), 4'h0, 8'h00, 7'd0);
    end
    expect_ev(9'h002, 4'h0, 8'h00, EN_ALU | EN_RW);
    expect_ev(9'h002, 4'h2, 8'h00, 7'd0);
    expect_ev(9'h003, 4'h2, 8'h00, 7'd0);
    expect_ev(9'h000, 4'h0, 8'h00, 7'd0);
    run_seg(66);

    done = 1'b1;
    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
